// File: rtl/ppu_pkg.sv
// Shared PPU types: LCD mode encoding, scheduler states and default line timing.
package ppu_pkg;

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        DRAW     = 2'd3
    } ppu_mode_t;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SCAN,
        ST_DRAW,
        ST_HBLANK,
        ST_VBLANK
    } sched_state_t;

    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_MODE2_DOTS    = 80;
    localparam int DEF_VISIBLE_LINES = 144;
    localparam int DEF_TOTAL_LINES   = 154;

    localparam logic [15:0] OAM_START = 16'hFE00;

    function automatic logic ppu_owns_oam(input ppu_mode_t m);
        return (m == OAM_SCAN) || (m == DRAW);
    endfunction

endpackage

// File: rtl/oam_bus_mux.sv
// Single-port OAM arbiter: the PPU fetcher owns the bus in modes 2/3, the CPU otherwise.
module oam_bus_mux
    import ppu_pkg::*;
(
    input  ppu_mode_t   i_mode,
    input  logic [15:0] i_ppu_a,
    input  logic [15:0] i_cpu_a,
    input  logic [7:0]  i_cpu_din,
    input  logic        i_cpu_wr,
    output logic [7:0]  o_cpu_dout,
    output logic [15:0] o_oam_a,
    output logic [7:0]  o_oam_din,
    output logic        o_oam_wr,
    input  logic [7:0]  i_oam_dout
);

    logic w_ppu_owns;

    assign w_ppu_owns = ppu_owns_oam(i_mode);

    // Locked-out CPU writes vanish and its reads float high.
    assign o_oam_a    = w_ppu_owns ? i_ppu_a : i_cpu_a;
    assign o_oam_wr   = w_ppu_owns ? 1'b0    : i_cpu_wr;
    assign o_oam_din  = w_ppu_owns ? 8'h00   : i_cpu_din;
    assign o_cpu_dout = w_ppu_owns ? 8'hFF   : i_oam_dout;

endmodule

// File: rtl/ppu_mode_scheduler.sv
// Per-scanline PPU sequencer: dot/line counters, mode FSM with fetcher handshakes,
// status pulses and OAM bus ownership.
module ppu_mode_scheduler
    import ppu_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int MODE2_DOTS    = DEF_MODE2_DOTS,
    parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_en,
    input  logic [7:0]  lyc,
    output logic        mode2_start,
    input  logic        mode2_done,
    output logic        mode3_start,
    input  logic        mode3_done,
    output logic [1:0]  mode,
    output logic [7:0]  ly,
    output logic [8:0]  dot,
    output logic        ly_eq_lyc,
    output logic        vblank_irq,
    output logic        stat_mode_edge,
    output logic        overrun,
    input  logic [15:0] ppu_oam_a,
    input  logic [15:0] cpu_oam_a,
    input  logic [7:0]  cpu_oam_din,
    input  logic        cpu_oam_wr,
    output logic [7:0]  cpu_oam_dout,
    output logic [15:0] oam_a,
    output logic [7:0]  oam_din,
    output logic        oam_wr,
    input  logic [7:0]  oam_dout
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SCAN_LAST = 9'(MODE2_DOTS - 1);
    localparam logic [7:0] LAST_LINE = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);

    sched_state_t r_state;
    ppu_mode_t    r_mode;
    logic [8:0]   r_dot;
    logic [7:0]   r_ly;
    logic         r_m2_seen;
    logic         r_mode2_start;
    logic         r_mode3_start;
    logic         r_ly_eq;
    logic         r_vblank_irq;
    logic         r_stat_edge;
    logic         r_overrun;

    logic         w_line_end;
    logic         w_m2_done_ok;
    logic         w_m3_done_ok;
    logic         w_scan_exit;
    logic [7:0]   w_next_ly;
    logic         w_next_visible;

    assign w_line_end     = (r_dot == LAST_DOT);
    // A done coincident with its own start pulse belongs to no transaction yet.
    assign w_m2_done_ok   = mode2_done && (r_state == ST_SCAN) && !r_mode2_start;
    assign w_m3_done_ok   = mode3_done && (r_state == ST_DRAW) && !r_mode3_start;
    assign w_scan_exit    = (r_dot >= SCAN_LAST) && (r_m2_seen || w_m2_done_ok);
    assign w_next_ly      = (r_ly == LAST_LINE) ? 8'd0 : r_ly + 8'd1;
    assign w_next_visible = (w_next_ly < VIS_LINES);

    always_ff @(posedge clk) begin
        if (rst || !lcd_en) begin
            r_state       <= ST_OFF;
            r_mode        <= HBLANK;
            r_dot         <= '0;
            r_ly          <= '0;
            r_m2_seen     <= 1'b0;
            r_mode2_start <= 1'b0;
            r_mode3_start <= 1'b0;
            r_ly_eq       <= 1'b0;
            r_vblank_irq  <= 1'b0;
            r_stat_edge   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_mode2_start <= 1'b0;
            r_mode3_start <= 1'b0;
            r_vblank_irq  <= 1'b0;
            r_stat_edge   <= 1'b0;
            r_overrun     <= 1'b0;
            r_ly_eq       <= (r_ly == lyc);
            if (r_state == ST_OFF) begin
                r_state       <= ST_SCAN;
                r_mode        <= OAM_SCAN;
                r_mode2_start <= 1'b1;
                r_stat_edge   <= 1'b1;
                r_m2_seen     <= 1'b0;
            end else if (w_line_end) begin
                // The line ends regardless of outstanding fetcher work.
                r_dot     <= '0;
                r_ly      <= w_next_ly;
                r_m2_seen <= 1'b0;
                r_overrun <= (r_state == ST_SCAN) || (r_state == ST_DRAW);
                if (w_next_visible) begin
                    r_state       <= ST_SCAN;
                    r_mode        <= OAM_SCAN;
                    r_mode2_start <= 1'b1;
                    r_stat_edge   <= (r_mode != OAM_SCAN);
                end else begin
                    r_state      <= ST_VBLANK;
                    r_mode       <= VBLANK;
                    r_vblank_irq <= (w_next_ly == VIS_LINES);
                    r_stat_edge  <= (r_mode != VBLANK);
                end
            end else begin
                r_dot <= r_dot + 9'd1;
                if (w_m2_done_ok) begin
                    r_m2_seen <= 1'b1;
                end
                if ((r_state == ST_SCAN) && w_scan_exit) begin
                    r_state       <= ST_DRAW;
                    r_mode        <= DRAW;
                    r_mode3_start <= 1'b1;
                    r_stat_edge   <= 1'b1;
                end else if ((r_state == ST_DRAW) && w_m3_done_ok) begin
                    r_state     <= ST_HBLANK;
                    r_mode      <= HBLANK;
                    r_stat_edge <= 1'b1;
                end
            end
        end
    end

    assign mode2_start    = r_mode2_start;
    assign mode3_start    = r_mode3_start;
    assign mode           = r_mode;
    assign ly             = r_ly;
    assign dot            = r_dot;
    assign ly_eq_lyc      = r_ly_eq;
    assign vblank_irq     = r_vblank_irq;
    assign stat_mode_edge = r_stat_edge;
    assign overrun        = r_overrun;

    oam_bus_mux u_oam_bus_mux (
        .i_mode     (r_mode),
        .i_ppu_a    (ppu_oam_a),
        .i_cpu_a    (cpu_oam_a),
        .i_cpu_din  (cpu_oam_din),
        .i_cpu_wr   (cpu_oam_wr),
        .o_cpu_dout (cpu_oam_dout),
        .o_oam_a    (oam_a),
        .o_oam_din  (oam_din),
        .o_oam_wr   (oam_wr),
        .i_oam_dout (oam_dout)
    );

endmodule

// File: tb/tb_ppu_mode_scheduler.sv
// Bench for ppu_mode_scheduler: per-line scenario table, directed OAM and lcd_en
// sequences, and a cycle-by-cycle reference model driven by random fetcher/CPU traffic.
module tb_ppu_mode_scheduler;

    localparam int DPL   = 456;
    localparam int M2D   = 80;
    localparam int VIS   = 144;
    localparam int TOT   = 154;
    localparam int FRAME = DPL * TOT;

    logic        clk = 1'b0;
    logic        rst, lcd_en, mode2_done, mode3_done, cpu_oam_wr, mem_clr;
    logic [7:0]  lyc, cpu_oam_din, oam_dout, cpu_oam_dout, oam_din, ly;
    logic [15:0] ppu_oam_a, cpu_oam_a, oam_a;
    logic        mode2_start, mode3_start, ly_eq_lyc, vblank_irq, stat_mode_edge, overrun, oam_wr;
    logic [1:0]  mode;
    logic [8:0]  dot;

    always #5 clk = ~clk;

    ppu_mode_scheduler dut (
        .clk(clk), .rst(rst), .lcd_en(lcd_en), .lyc(lyc),
        .mode2_start(mode2_start), .mode2_done(mode2_done),
        .mode3_start(mode3_start), .mode3_done(mode3_done),
        .mode(mode), .ly(ly), .dot(dot), .ly_eq_lyc(ly_eq_lyc),
        .vblank_irq(vblank_irq), .stat_mode_edge(stat_mode_edge), .overrun(overrun),
        .ppu_oam_a(ppu_oam_a), .cpu_oam_a(cpu_oam_a), .cpu_oam_din(cpu_oam_din),
        .cpu_oam_wr(cpu_oam_wr), .cpu_oam_dout(cpu_oam_dout),
        .oam_a(oam_a), .oam_din(oam_din), .oam_wr(oam_wr), .oam_dout(oam_dout)
    );

    // OAM RAM with two-cycle read latency.
    logic [7:0] mem [0:255];
    logic [7:0] rd_p0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (oam_wr) begin
            mem[oam_a[7:0]] <= oam_din;
        end
        rd_p0    <= mem[oam_a[7:0]];
        oam_dout <= rd_p0;
    end

    // Reference model: m_t is cycles since enable (-1 = off); m_d2/m_d3 are the dots
    // at which the current line's accepted done pulses arrived (-1 = not yet).
    int m_t, m_d2, m_d3, m_prev_mode;
    bit m_ovr, m_eq;
    int n_checks = 0;
    int n_err    = 0;

    function automatic int m_ly();
        return (m_t < 0) ? 0 : (m_t / DPL) % TOT;
    endfunction

    function automatic int m_dot();
        return (m_t < 0) ? 0 : m_t % DPL;
    endfunction

    function automatic int m_ds();
        return ((m_d2 > M2D - 1) ? m_d2 : M2D - 1) + 1;
    endfunction

    function automatic int m_mode();
        if (m_t < 0) return 0;
        if (m_ly() >= VIS) return 1;
        if (m_d2 < 0 || m_dot() < m_ds()) return 2;
        if (m_d3 < 0) return 3;
        return 0;
    endfunction

    task automatic model_advance();
        int md, d, l;
        md = m_mode();
        d  = m_dot();
        l  = m_ly();
        if (rst || !lcd_en) begin
            m_t = -1; m_d2 = -1; m_d3 = -1; m_ovr = 0; m_eq = 0; m_prev_mode = 0;
            return;
        end
        m_eq        = (l == int'(lyc));
        m_prev_mode = md;
        if (m_t < 0) begin
            m_t = 0; m_d2 = -1; m_d3 = -1; m_ovr = 0;
            return;
        end
        if (l < VIS) begin
            if (m_d2 < 0 && mode2_done && d >= 1) m_d2 = d;
            else if (md == 3 && m_d3 < 0 && mode3_done && d > m_ds()) m_d3 = d;
        end
        m_ovr = (d == DPL - 1) && (md == 2 || md == 3);
        m_t   = (m_t + 1) % FRAME;
        if (m_dot() == 0) begin
            m_d2 = -1; m_d3 = -1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int md;
        bit own;
        md  = m_mode();
        own = (md >= 2);
        check("mode", int'(mode), md);
        check("ly", int'(ly), m_ly());
        check("dot", int'(dot), m_dot());
        check("mode2_start", int'(mode2_start), int'(m_t >= 0 && m_ly() < VIS && m_dot() == 0));
        check("mode3_start", int'(mode3_start), int'(md == 3 && m_dot() == m_ds()));
        check("vblank_irq", int'(vblank_irq), int'(m_t >= 0 && m_ly() == VIS && m_dot() == 0));
        check("stat_mode_edge", int'(stat_mode_edge), int'(m_t >= 0 && md != m_prev_mode));
        check("overrun", int'(overrun), int'(m_ovr));
        check("ly_eq_lyc", int'(ly_eq_lyc), int'(m_eq));
        check("oam_a", int'(oam_a), own ? int'(ppu_oam_a) : int'(cpu_oam_a));
        check("oam_wr", int'(oam_wr), own ? 0 : int'(cpu_oam_wr));
        check("oam_din", int'(oam_din), own ? 0 : int'(cpu_oam_din));
        check("cpu_oam_dout", int'(cpu_oam_dout), own ? 255 : int'(oam_dout));
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
        check_all();
    endtask

    typedef struct {
        int d2;        // dot of mode2_done, -1 = none
        int d3;        // dot of mode3_done, -1 = none
        int exp_draw;  // first dot in mode 3, -1 = never
        int exp_hbl;   // first dot in mode 0, -1 = never
        int exp_ovr;
    } line_vec_t;

    // Entered at dot 0 of visible line line_no; leaves at dot 0 of the next line.
    task automatic run_line(input line_vec_t v, input int line_no);
        int first3, first0;
        first3 = -1;
        first0 = -1;
        check("line_mode2_start", int'(mode2_start), 1);
        for (int k = 0; k < DPL; k++) begin
            if (mode == 2'd3 && first3 < 0) begin
                first3 = k;
                check("line_mode3_start", int'(mode3_start), 1);
            end
            if (mode == 2'd0 && first0 < 0) first0 = k;
            mode2_done = (k == v.d2);
            mode3_done = (k == v.d3);
            tick();
        end
        mode2_done = 1'b0;
        mode3_done = 1'b0;
        check("line_draw_dot", first3, v.exp_draw);
        check("line_hblank_dot", first0, v.exp_hbl);
        check("line_overrun", int'(overrun), v.exp_ovr);
        check("line_next_ly", int'(ly), line_no + 1);
        check("line_next_mode", int'(mode), 2);
    endtask

    initial begin
        line_vec_t lv [7];
        int vb_cnt, vb_cycle, eq_cnt, max_ly;

        lv[0] = '{40, 252, 80, 253, 0};
        lv[1] = '{100, 300, 101, 301, 0};
        lv[2] = '{40, -1, 80, -1, 1};
        lv[3] = '{-1, -1, -1, -1, 1};
        lv[4] = '{0, 200, -1, -1, 1};
        lv[5] = '{79, 80, 80, -1, 1};
        lv[6] = '{79, 81, 80, 82, 0};

        rst = 1'b1; lcd_en = 1'b0; lyc = 8'd0; mode2_done = 1'b0; mode3_done = 1'b0;
        ppu_oam_a = 16'hFE00; cpu_oam_a = 16'h0000; cpu_oam_din = 8'h00;
        cpu_oam_wr = 1'b0; mem_clr = 1'b0;
        m_t = -1; m_d2 = -1; m_d3 = -1; m_prev_mode = 0; m_ovr = 0; m_eq = 0;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        lcd_en = 1'b1;
        tick();
        check("en_mode2_start", int'(mode2_start), 1);
        check("en_mode", int'(mode), 2);
        for (int i = 0; i < 7; i++) run_line(lv[i], i);

        // OAM arbitration on line 7.
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        cpu_oam_a = 16'hFE10; cpu_oam_din = 8'hA5; cpu_oam_wr = 1'b1;
        #1;
        check("oam_locked_wr", int'(oam_wr), 0);
        check("oam_locked_dout", int'(cpu_oam_dout), 255);
        check("oam_locked_addr", int'(oam_a), 16'hFE00);
        tick();
        cpu_oam_wr = 1'b0;
        for (int n = 0; n < DPL && m_dot() != 150; n++) begin
            mode2_done = (m_dot() == 40);
            mode3_done = (m_dot() == 100);
            tick();
        end
        mode2_done = 1'b0;
        mode3_done = 1'b0;
        check("oam_hblank_mode", int'(mode), 0);
        check("oam_dropped_write", int'(cpu_oam_dout), 0);
        cpu_oam_wr = 1'b1;
        #1;
        check("oam_open_wr", int'(oam_wr), 1);
        tick();
        cpu_oam_wr = 1'b0;
        tick();
        tick();
        check("oam_readback", int'(cpu_oam_dout), 8'hA5);
        for (int n = 0; n < DPL && m_dot() != 0; n++) tick();

        // lcd_en toggled off and on, then dropped at line 5 dot 200.
        lcd_en = 1'b0;
        tick();
        check("off_mode", int'(mode), 0);
        lcd_en = 1'b1;
        tick();
        check("reen_mode2_start", int'(mode2_start), 1);
        for (int n = 0; n < 5 * DPL + 200; n++) begin
            mode2_done = (m_dot() == 40);
            mode3_done = (m_dot() == 252);
            tick();
        end
        mode2_done = 1'b0;
        mode3_done = 1'b0;
        check("pre_drop_ly", int'(ly), 5);
        check("pre_drop_dot", int'(dot), 200);
        lcd_en = 1'b0;
        tick();
        check("drop_ly", int'(ly), 0);
        check("drop_mode", int'(mode), 0);
        check("drop_dot", int'(dot), 0);
        mode3_done = 1'b1;
        tick();
        mode3_done = 1'b0;
        check("stray_done_mode", int'(mode), 0);
        check("stray_done_m3start", int'(mode3_start), 0);
        lyc = 8'd10;
        lcd_en = 1'b1;
        tick();
        check("drop_reen_mode2_start", int'(mode2_start), 1);
        check("drop_reen_mode", int'(mode), 2);

        // One full frame with random fetcher and CPU traffic.
        vb_cnt = 0; vb_cycle = -1; eq_cnt = 0; max_ly = 0;
        for (int c = 1; c <= FRAME; c++) begin
            mode2_done  = ($urandom_range(0, 29) == 0);
            mode3_done  = ($urandom_range(0, 29) == 0);
            ppu_oam_a   = 16'($urandom);
            cpu_oam_a   = 16'($urandom);
            cpu_oam_din = 8'($urandom);
            cpu_oam_wr  = ($urandom_range(0, 3) == 0);
            tick();
            if (vblank_irq) begin
                vb_cnt++;
                vb_cycle = c;
            end
            if (ly_eq_lyc) eq_cnt++;
            if (int'(ly) > max_ly) max_ly = int'(ly);
        end
        check("frame_vblank_count", vb_cnt, 1);
        check("frame_vblank_cycle", vb_cycle, VIS * DPL);
        check("frame_lyeq_cycles", eq_cnt, DPL);
        check("frame_max_ly", max_ly, TOT - 1);
        check("frame_wrap_ly", int'(ly), 0);
        check("frame_wrap_dot", int'(dot), 0);

        // Random lcd_en glitches and lyc changes.
        for (int c = 0; c < 3000; c++) begin
            lcd_en     = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 99) == 0) lyc = 8'($urandom_range(0, 3));
            mode2_done = ($urandom_range(0, 19) == 0);
            mode3_done = ($urandom_range(0, 19) == 0);
            cpu_oam_a  = 16'($urandom);
            cpu_oam_wr = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
